// File: rtl/serializer_pkg.sv
// Shared types for the bit serializer: FSM state encoding and default word width.
// The PARITY encoding is only reached when SERIAL_PARITY_EN is defined.
package serializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

endpackage

// File: rtl/ser_bit_counter.sv
// Bit counter for the serializer: clears to zero on load, then counts 0..WIDTH-1.
// It saturates at WIDTH-1 and flags it on term, so it never wraps inside a word.
module ser_bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic term
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign term = (count == LAST);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with registered x/x_valid/done outputs.
// Define SERIAL_PARITY_EN to append an even-parity bit after each word.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             x,
  output logic             x_valid,
  output logic             done
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic             x_nxt, x_valid_nxt, done_nxt;
  logic             cnt_clear, cnt_en, term;
`ifdef SERIAL_PARITY_EN
  logic             par, par_nxt;
`endif

  // The register always holds the bits not yet driven, so the outgoing bit sits at one end.
  function automatic logic out_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign ready = (state == IDLE);

  ser_bit_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clear(cnt_clear),
    .en   (cnt_en),
    .term (term)
  );

  always_comb begin
    state_nxt   = state;
    sreg_nxt    = sreg;
    x_nxt       = 1'b0;
    x_valid_nxt = 1'b0;
    done_nxt    = 1'b0;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;
`ifdef SERIAL_PARITY_EN
    par_nxt     = par;
`endif
    case (state)
      IDLE: begin
        if (load) begin
          state_nxt   = SHIFT;
          sreg_nxt    = shift_out(din);
          x_nxt       = out_bit(din);
          x_valid_nxt = 1'b1;
          cnt_clear   = 1'b1;
`ifdef SERIAL_PARITY_EN
          par_nxt     = ^din;
`endif
        end
      end
      SHIFT: begin
        cnt_en = 1'b1;
        if (term) begin
`ifdef SERIAL_PARITY_EN
          state_nxt   = PARITY;
          x_nxt       = par;
          x_valid_nxt = 1'b1;
`else
          state_nxt   = IDLE;
          done_nxt    = 1'b1;
`endif
        end else begin
          sreg_nxt    = shift_out(sreg);
          x_nxt       = out_bit(sreg);
          x_valid_nxt = 1'b1;
        end
      end
`ifdef SERIAL_PARITY_EN
      PARITY: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sreg    <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      done    <= 1'b0;
`ifdef SERIAL_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      sreg    <= sreg_nxt;
      x       <= x_nxt;
      x_valid <= x_valid_nxt;
      done    <= done_nxt;
`ifdef SERIAL_PARITY_EN
      par     <= par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: an MSB-first and an LSB-first instance side by side.
// Expected bits are queued when a word is driven and popped whenever x_valid is seen.
module tb_bit_serializer;

  localparam int W = 8;
`ifdef SERIAL_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = W + PAR;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din_m, din_l;
  logic         load_m, load_l;
  logic         ready_m, x_m, xv_m, done_m;
  logic         ready_l, x_l, xv_l, done_l;

  int n_cmp = 0;
  int n_err = 0;
  bit q_m[$];
  bit q_l[$];
  bit e_m, e_l;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset(reset), .din(din_m), .load(load_m),
    .ready(ready_m), .x(x_m), .x_valid(xv_m), .done(done_m)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset(reset), .din(din_l), .load(load_l),
    .ready(ready_l), .x(x_l), .x_valid(xv_l), .done(done_l)
  );

  // Scoreboard monitors: every valid bit must match the next queued expectation.
  always @(negedge clk) begin
    if (xv_m === 1'b1) begin
      n_cmp++;
      if (q_m.size() == 0) begin
        n_err++;
        $display("FAIL msb_stream: x=%0b valid with nothing expected", x_m);
      end else begin
        e_m = q_m.pop_front();
        if (x_m !== e_m) begin
          n_err++;
          $display("FAIL msb_stream: x=%0b expected %0b", x_m, e_m);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (xv_l === 1'b1) begin
      n_cmp++;
      if (q_l.size() == 0) begin
        n_err++;
        $display("FAIL lsb_stream: x=%0b valid with nothing expected", x_l);
      end else begin
        e_l = q_l.pop_front();
        if (x_l !== e_l) begin
          n_err++;
          $display("FAIL lsb_stream: x=%0b expected %0b", x_l, e_l);
        end
      end
    end
  end

  task automatic push_word(input logic [W-1:0] w, input bit msb);
    for (int i = 0; i < W; i++) begin
      if (msb) q_m.push_back(w[W-1-i]);
      else     q_l.push_back(w[i]);
    end
    if (PAR != 0) begin
      if (msb) q_m.push_back(^w);
      else     q_l.push_back(^w);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; load_m = 1'b0; load_l = 1'b0; din_m = '0; din_l = '0;
    #1;
    n_cmp++;
    if (ready_m !== 1'b1 || x_m !== 1'b0 || xv_m !== 1'b0 || done_m !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: ready=%b x=%b x_valid=%b done=%b expected 1 0 0 0",
               ready_m, x_m, xv_m, done_m);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (ready_l !== 1'b1 || xv_l !== 1'b0 || done_l !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: ready=%b x_valid=%b done=%b expected 1 0 0", ready_l, xv_l, done_l);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic(input logic [W-1:0] w);
    push_word(w, 1'b1);
    @(negedge clk); din_m = w; load_m = 1'b1;
    @(negedge clk); load_m = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (xv_m !== 1'b1 || ready_m !== 1'b0 || done_m !== 1'b0) begin
        n_err++;
        $display("FAIL basic_busy: cycle %0d x_valid=%b ready=%b done=%b expected 1 0 0",
                 i, xv_m, ready_m, done_m);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done_m !== 1'b1 || xv_m !== 1'b0 || ready_m !== 1'b1 || x_m !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done: done=%b x_valid=%b ready=%b x=%b expected 1 0 1 0",
               done_m, xv_m, ready_m, x_m);
    end
    @(negedge clk);
    n_cmp++;
    if (done_m !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done_width: done=%b expected 0", done_m);
    end
  endtask

  task automatic test_lsb;
    int nv;
    bit seen;
    nv = 0; seen = 1'b0;
    push_word(8'hB2, 1'b0);
    @(negedge clk); din_l = 8'hB2; load_l = 1'b1;
    @(negedge clk); load_l = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (k > 0) @(negedge clk);
      if (done_l === 1'b1) seen = 1'b1;
      else if (xv_l === 1'b1) nv++;
    end
    n_cmp++;
    if (!seen || nv != NB) begin
      n_err++;
      $display("FAIL lsb_length: valid cycles=%0d done_seen=%0b expected %0d 1", nv, seen, NB);
    end
  endtask

  task automatic test_parity;
    int nv;
    bit seen;
    nv = 0; seen = 1'b0;
    push_word(8'h07, 1'b1);
    @(negedge clk); din_m = 8'h07; load_m = 1'b1;
    @(negedge clk); load_m = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (k > 0) @(negedge clk);
      if (done_m === 1'b1) seen = 1'b1;
      else if (xv_m === 1'b1) nv++;
    end
    n_cmp++;
    if (!seen || nv != NB) begin
      n_err++;
      $display("FAIL parity_length: valid cycles=%0d done_seen=%0b expected %0d 1", nv, seen, NB);
    end
  endtask

  task automatic test_back_to_back;
    push_word(8'hA5, 1'b1);
    push_word(8'h3C, 1'b1);
    @(negedge clk); din_m = 8'hA5; load_m = 1'b1;
    @(negedge clk); din_m = 8'h3C;
    for (int i = 1; i < NB; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ready_m !== 1'b0 || xv_m !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_first_word: cycle %0d ready=%b x_valid=%b expected 0 1", i, ready_m, xv_m);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done_m !== 1'b1 || ready_m !== 1'b1 || xv_m !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_gap: done=%b ready=%b x_valid=%b expected 1 1 0", done_m, ready_m, xv_m);
    end
    @(negedge clk); load_m = 1'b0;
    n_cmp++;
    if (xv_m !== 1'b1 || done_m !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_restart: x_valid=%b done=%b expected 1 0", xv_m, done_m);
    end
    repeat (NB - 1) @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (done_m !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_second_done: done=%b expected 1", done_m);
    end
  endtask

  task automatic test_reset_mid;
    push_word(8'hFF, 1'b1);
    @(negedge clk); din_m = 8'hFF; load_m = 1'b1;
    @(negedge clk); load_m = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (x_m !== 1'b0 || xv_m !== 1'b0 || ready_m !== 1'b1 || done_m !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: x=%b x_valid=%b ready=%b done=%b expected 0 0 1 0",
               x_m, xv_m, ready_m, done_m);
    end
    q_m.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (done_m !== 1'b0 || xv_m !== 1'b0) begin
        n_err++;
        $display("FAIL reset_no_done: done=%b x_valid=%b expected 0 0", done_m, xv_m);
      end
    end
    reset = 1'b1;
    test_basic(8'h81);
  endtask

  initial begin
    test_reset();
    test_basic(8'hB2);
    test_lsb();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    test_basic(8'h6D);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (q_m.size() != 0 || q_l.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: left msb=%0d lsb=%0d expected 0 0", q_m.size(), q_l.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits; legal range 2..16.
REQ-002 Parameter MSB_FIRST, default 1: 1 = shift MSB first, 0 = shift LSB first.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 din  input  WIDTH  parallel word to serialize; sampled only on an accepted load.
REQ-006 load  input  1  request to accept din.
REQ-007 ready  output  1  high when a load will be accepted.
REQ-008 x  output  1  registered serial bit stream; feeds the downstream sequence detector's x input.
REQ-009 x_valid  output  1  high on every cycle where x carries a data or parity bit.
REQ-010 done  output  1  one-cycle pulse after the final bit of a word.

Function
REQ-011 States: IDLE, SHIFT, and PARITY (PARITY exists only with SERIAL_PARITY_EN); encoding defined in the package.
REQ-012 IDLE: ready=1, x=0, x_valid=0.
REQ-013 A load is accepted when load=1 and ready=1 at a rising edge: din is copied to the shift register, the bit counter is set to 0, and the FSM enters SHIFT.
REQ-014 Latency: the first bit appears on x with x_valid=1 in the cycle directly after the accepting edge.
REQ-015 SHIFT: one bit per cycle for exactly WIDTH consecutive cycles, ordered per MSB_FIRST; ready=0 throughout.
REQ-016 Bit counter width is clog2(WIDTH+1); it counts 0..WIDTH-1 and never wraps inside a word.
REQ-017 After the last data bit, the FSM enters PARITY if compiled in, otherwise IDLE.
REQ-018 done=1 for exactly the first IDLE cycle after a word completes; in that cycle ready=1 and x_valid=0.
REQ-019 A load asserted in the done cycle is accepted, giving back-to-back words with exactly one idle cycle between them.
REQ-020 When ready=0, load is ignored; din changes while shifting have no effect.
REQ-021 The design has no abort input; once accepted, a word always completes.

Reset
REQ-022 While reset=0, all of the following hold immediately, without waiting for a clock edge: FSM=IDLE, shift register=0, counter=0, x=0, x_valid=0, done=0, ready=1.
REQ-023 Reset asserted mid-word discards the word, and no done pulse is produced for it.
REQ-024 On release of reset, the first accepted load behaves exactly per REQ-013/014.

Configuration
REQ-025 Macro SERIAL_PARITY_EN: when defined, after the WIDTH data bits the block spends one PARITY cycle driving x = XOR of all bits of the captured word (even parity), with x_valid=1; a word then takes WIDTH+1 valid cycles.
REQ-026 Without SERIAL_PARITY_EN, no PARITY state or parity logic exists, and a word takes WIDTH valid cycles.

Structure
REQ-027 Package serializer_pkg holds the state typedef (IDLE, SHIFT, PARITY) and the constant for the default WIDTH.
REQ-028 A single sub-module, ser_bit_counter (load-to-zero, enable, terminal-count flag), is instantiated; the shift register and FSM remain in bit_serializer.

Verification
REQ-029 Basic word: WIDTH=8, MSB_FIRST=1, din=8'hB2 -> x sequence 1,0,1,1,0,0,1,0 over 8 cycles with x_valid=1; done pulses in the following cycle.
REQ-030 LSB-first: MSB_FIRST=0, din=8'hB2 -> x sequence 0,1,0,0,1,1,0,1.
REQ-031 Parity: SERIAL_PARITY_EN defined, din=8'h07 -> 8 data bits followed by parity bit 1; done pulses after the 9th valid cycle.
REQ-032 Back-to-back and ignored load: load held high continuously with din=8'hA5 then 8'h3C -> the second word starts the cycle after done; a din change mid-word does not alter the bits of the current word.
REQ-033 Reset mid-word: reset=0 after the 3rd bit of 8'hFF -> x=0, x_valid=0 and ready=1 immediately with no done pulse; after release, 8'h81 serializes correctly.
REQ-034 Pipeline with detector: drive x/x_valid into the existing detector with stream 8'b0110_1101 -> the detector output y matches the scoreboard model bit for bit.
